// File: rtl/i2c_arb_pkg.sv
// Shared state, descriptor types and timing defaults for the I2C transaction arbiter.
// Companion to i2c_txn_arbiter (optional WAIT timeout via I2C_ARB_TIMEOUT_EN).
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } arb_state_t;

  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  ptr;
    logic [15:0] wdata;
    logic [1:0]  len;
  } txn_desc_t;

  // tBUF of 1.3 us at 100 MHz, and a generous engine stall bound
  localparam int BUS_FREE_CYC_DEFAULT = 130;
  localparam int TIMEOUT_CYC_DEFAULT  = 100000;

  function automatic logic len_is_legal(input logic [1:0] len);
    return (len == 2'd1) || (len == 2'd2);
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester and engine signal bundle for i2c_txn_arbiter.
// slave = arbiter side, master = requesters/engine side.
interface i2c_txn_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [7*N_REQ-1:0]  req_addr;
  logic [N_REQ-1:0]    req_rw;
  logic [8*N_REQ-1:0]  req_ptr;
  logic [16*N_REQ-1:0] req_wdata;
  logic [2*N_REQ-1:0]  req_len;

  logic [N_REQ-1:0]    rsp_valid;
  logic [15:0]         rsp_rdata;
  logic                rsp_err;

  logic                eng_cmd_valid;
  logic                eng_cmd_ready;
  logic [6:0]          eng_addr;
  logic                eng_rw;
  logic [7:0]          eng_ptr;
  logic [15:0]         eng_wdata;
  logic [1:0]          eng_len;
  logic                eng_done;
  logic [15:0]         eng_rdata;
  logic                eng_nack;
  logic                eng_abort;

  logic                busy;
  logic [IDW-1:0]      grant_id;

  modport slave (
    input  req_valid, req_addr, req_rw, req_ptr, req_wdata, req_len,
    input  eng_cmd_ready, eng_done, eng_rdata, eng_nack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output eng_cmd_valid, eng_addr, eng_rw, eng_ptr, eng_wdata, eng_len, eng_abort,
    output busy, grant_id
  );

  modport master (
    output req_valid, req_addr, req_rw, req_ptr, req_wdata, req_len,
    output eng_cmd_ready, eng_done, eng_rdata, eng_nack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  eng_cmd_valid, eng_addr, eng_rw, eng_ptr, eng_wdata, eng_len, eng_abort,
    input  busy, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// ptr must be below N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      cand = sum[IDW-1:0];
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C transaction engine among N_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to bound WAIT by TIMEOUT_CYC with an engine abort.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int IDW          = 2,
  parameter int BUS_FREE_CYC = BUS_FREE_CYC_DEFAULT,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  i2c_txn_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > 8 || (1 << IDW) < N_REQ || BUS_FREE_CYC < 1 || TIMEOUT_CYC < 1)
  begin : g_param_check
    $error("i2c_txn_arbiter: illegal parameter combination");
  end

  arb_state_t       state;
  txn_desc_t        desc_q;
  txn_desc_t        sel_desc;
  txn_desc_t        req_desc [N_REQ];
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_q;
  logic [N_REQ-1:0] owner_q;
  logic [N_REQ-1:0] req_ready_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [15:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic             cmd_valid_q;
  logic             busy_q;
  logic [31:0]      gap_cnt;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0]      wait_cnt;
  logic             abort_q;
`endif

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_desc[g] = '{addr:  bus.req_addr[7*g +: 7],
                           rw:    bus.req_rw[g],
                           ptr:   bus.req_ptr[8*g +: 8],
                           wdata: bus.req_wdata[16*g +: 16],
                           len:   bus.req_len[2*g +: 2]};
  end

  assign sel_desc = req_desc[arb_idx];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Illegal lengths complete immediately with an error and never reach the engine
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      desc_q      <= '0;
      rr_ptr      <= '0;
      grant_q     <= '0;
      owner_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      gap_cnt     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      abort_q     <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            desc_q      <= sel_desc;
            grant_q     <= arb_idx;
            owner_q     <= arb_gnt;
            req_ready_q <= arb_gnt;
            rr_ptr      <= (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            busy_q      <= 1'b1;
            if (len_is_legal(sel_desc.len)) begin
              state       <= ST_ISSUE;
              cmd_valid_q <= 1'b1;
            end else begin
              state       <= ST_RESP;
              rsp_valid_q <= arb_gnt;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end

        ST_ISSUE: begin
          if (bus.eng_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state       <= ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end

        // A completion in the same cycle as the timeout takes priority
        ST_WAIT: begin
          if (bus.eng_done) begin
            rsp_rdata_q <= bus.eng_rdata;
            rsp_err_q   <= bus.eng_nack;
            rsp_valid_q <= owner_q;
            state       <= ST_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) begin
            abort_q     <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_q;
            state       <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end

        ST_RESP: begin
          rsp_valid_q <= '0;
          gap_cnt     <= '0;
          state       <= ST_GAP;
        end

        ST_GAP: begin
          if (gap_cnt == 32'(BUS_FREE_CYC - 1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.eng_cmd_valid = cmd_valid_q;
  assign bus.eng_addr      = desc_q.addr;
  assign bus.eng_rw        = desc_q.rw;
  assign bus.eng_ptr       = desc_q.ptr;
  assign bus.eng_wdata     = desc_q.wdata;
  assign bus.eng_len       = desc_q.len;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign bus.eng_abort     = abort_q;
`else
  assign bus.eng_abort     = 1'b0;
`endif

endmodule
